// File: rtl/cache_types.sv
// Shared cache-side types: burst adapter state encoding and burst memory geometry.
package cache_types;

    localparam int BURST_BEAT_BITS = 64;
    localparam int BURST_BEATS     = 4;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_REQ,
        RD_DATA,
        DONE
    } burst_state_t;

endpackage

// File: rtl/l2_dfp_burst_adapter.sv
// Bridges the L2 line port to a narrow burst memory: writebacks are serialised into beats, fills are
// reassembled from beats. Build option L2_BURST_RADDR_CHECK_EN drops read beats whose tag mismatches.
module l2_dfp_burst_adapter
    import cache_types::*;
#(
    parameter int LINE_BITS = BURST_BEATS * BURST_BEAT_BITS,
    parameter int BEAT_BITS = BURST_BEAT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [31:0]          dfp_addr,
    input  logic                 dfp_read,
    input  logic                 dfp_write,
    input  logic [LINE_BITS-1:0] dfp_wdata,
    output logic [LINE_BITS-1:0] dfp_rdata,
    output logic                 dfp_resp,

    output logic [31:0]          bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_BITS-1:0] bmem_wdata,
    input  logic                 bmem_ready,
    input  logic [31:0]          bmem_raddr,
    input  logic [BEAT_BITS-1:0] bmem_rdata,
    input  logic                 bmem_rvalid
);

    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_BITS / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [31:0]      LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);

    burst_state_t         state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [31:0]          addr_q;
    logic [LINE_BITS-1:0] wdata_q;
    logic [LINE_BITS-1:0] rdata_q;
    logic [BEAT_BITS-1:0] bmem_wdata_q;
    logic                 resp_q;
    logic                 read_q;
    logic                 write_q;

    logic [31:0]          line_addr_d;
    logic                 beat_hit;
    logic [LINE_BITS-1:0] rd_line;
    logic [BEAT_BITS-1:0] wbeat  [BEATS];
    logic [BEAT_BITS-1:0] slot_q [BEATS-1];

    assign line_addr_d = dfp_addr & LINE_MASK;

`ifdef L2_BURST_RADDR_CHECK_EN
    assign beat_hit = bmem_rvalid && (bmem_raddr == addr_q);
`else
    assign beat_hit = bmem_rvalid;
    logic unused_raddr;
    assign unused_raddr = ^bmem_raddr;
`endif

    // Write line viewed as an array of beats, beat 0 in the least significant bits.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_wbeat
            assign wbeat[gi] = wdata_q[gi*BEAT_BITS +: BEAT_BITS];
        end
    endgenerate

    // Early read beats park in slots; the final beat bypasses straight into the assembled line.
    generate
        for (genvar gi = 0; gi < BEATS - 1; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_q[gi] <= '0;
                end else if (state_q == RD_DATA && beat_hit && cnt_q == CNT_W'(gi)) begin
                    slot_q[gi] <= bmem_rdata;
                end
            end
            assign rd_line[gi*BEAT_BITS +: BEAT_BITS] = slot_q[gi];
        end
    endgenerate
    assign rd_line[LINE_BITS-1 -: BEAT_BITS] = bmem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            bmem_wdata_q <= '0;
            resp_q       <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Write wins if both requests are (illegally) raised together.
                    if (dfp_write) begin
                        state_q      <= WRITE;
                        addr_q       <= line_addr_d;
                        wdata_q      <= dfp_wdata;
                        bmem_wdata_q <= dfp_wdata[BEAT_BITS-1:0];
                        cnt_q        <= '0;
                        write_q      <= 1'b1;
                    end else if (dfp_read) begin
                        state_q <= RD_REQ;
                        addr_q  <= line_addr_d;
                        cnt_q   <= '0;
                        read_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (bmem_ready) begin
                        if (cnt_q == LAST_BEAT) begin
                            state_q <= DONE;
                            cnt_q   <= '0;
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                        end else begin
                            cnt_q        <= cnt_q + CNT_W'(1);
                            bmem_wdata_q <= wbeat[cnt_q + CNT_W'(1)];
                        end
                    end
                end
                RD_REQ: begin
                    if (bmem_ready) begin
                        state_q <= RD_DATA;
                        read_q  <= 1'b0;
                    end
                end
                RD_DATA: begin
                    if (beat_hit) begin
                        if (cnt_q == LAST_BEAT) begin
                            state_q <= DONE;
                            cnt_q   <= '0;
                            rdata_q <= rd_line;
                            resp_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    resp_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    resp_q  <= 1'b0;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    assign dfp_rdata  = rdata_q;
    assign dfp_resp   = resp_q;
    assign bmem_addr  = addr_q;
    assign bmem_read  = read_q;
    assign bmem_write = write_q;
    assign bmem_wdata = bmem_wdata_q;

endmodule
